// File: rtl/man_rx_pkg.sv
// Shared types for the Manchester receive controller: FSM states, error codes
// and the default frame sync byte. MAN_RX_PARITY_EN adds the PARITY state.
package man_rx_pkg;

  localparam logic [7:0] DefaultSync = 8'hD5;

  typedef enum logic [2:0] {
    StIdle,
    StHunt,
    StPayload,
`ifdef MAN_RX_PARITY_EN
    StParity,
`endif
    StDone
  } rx_state_e;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrTimeout  = 2'd1,
    ErrOverflow = 2'd2,
    ErrParity   = 2'd3
  } err_code_e;

endpackage

// File: rtl/manchester_rx_ctrl_if.sv
// Byte stream handshake and frame status of the Manchester receive controller.
// master: the receiver side; slave: the byte consumer.
interface manchester_rx_ctrl_if;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       frame_start;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  modport master (
    output byte_data,
    output byte_valid,
    input  byte_ready,
    output frame_start,
    output frame_done,
    output frame_err,
    output err_code,
    output busy
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    output byte_ready,
    input  frame_start,
    input  frame_done,
    input  frame_err,
    input  err_code,
    input  busy
  );

endinterface

// File: rtl/man_edge_sync.sv
// Brings the decoder's bit clock and data into the clk domain through two flops
// each and flags the rising edge of the synchronized bit clock. A bit is acted on
// three clk edges after the raw bit_clk rise.
module man_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  input  logic data,
  output logic data_sync,
  output logic rise
);

  logic [1:0] strobe_q;
  logic [1:0] data_q;
  logic       strobe_prev_q;

  // Data shares the strobe's stage count so both arrive aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe_q      <= '0;
      data_q        <= '0;
      strobe_prev_q <= 1'b0;
    end else begin
      strobe_q      <= {strobe_q[0], strobe};
      data_q        <= {data_q[0], data};
      strobe_prev_q <= strobe_q[1];
    end
  end

  assign rise      = strobe_q[1] & ~strobe_prev_q;
  assign data_sync = data_q[1];

endmodule

// File: rtl/manchester_rx_ctrl.sv
// Frame receiver behind a Manchester decoder: hunts for the sync byte, assembles
// PAYLOAD_BYTES bytes MSB first onto a valid/ready port and reports frame start,
// completion and aborts (timeout, overflow, parity).
// Define MAN_RX_PARITY_EN to append and check one even-parity bit per frame.
module manchester_rx_ctrl
  import man_rx_pkg::*;
#(
  parameter logic [7:0]  SYNC_PATTERN  = DefaultSync,
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter int unsigned TIMEOUT_CYC   = 640
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 bit_clk,
  input  logic                 bit_data,
  manchester_rx_ctrl_if.master rx
);

  localparam logic [3:0] LastByte = 4'(PAYLOAD_BYTES - 1);
  localparam logic [9:0] TmoLimit = 10'(TIMEOUT_CYC);

  rx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] byte_cnt_q, byte_cnt_d;
  logic [9:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       byte_valid_q, byte_valid_d;
  logic       frame_start_q, frame_start_d;
  logic       frame_done_q, frame_done_d;
  logic       frame_err_q, frame_err_d;
  err_code_e  err_code_q, err_code_d;
`ifdef MAN_RX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  logic       bit_rise;
  logic       bit_sync;
  logic [7:0] shifted;
  logic       can_load;
  logic       tmo_hit;

  man_edge_sync u_edge_sync (
    .clk       (clk),
    .rst       (rst),
    .strobe    (bit_clk),
    .data      (bit_data),
    .data_sync (bit_sync),
    .rise      (bit_rise)
  );

  assign shifted  = {shift_q[6:0], bit_sync};
  assign can_load = ~byte_valid_q | rx.byte_ready;
  // A sampled edge in the limit cycle takes priority over the timeout.
  assign tmo_hit  = ~bit_rise & (tmo_cnt_q == TmoLimit);

  // Next-state, byte assembly, output handshake and status pulses.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    tmo_cnt_d     = '0;
    byte_data_d   = byte_data_q;
    byte_valid_d  = byte_valid_q & ~rx.byte_ready;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
`ifdef MAN_RX_PARITY_EN
    parity_d      = parity_q;
`endif

    if (!enable) begin
      // Silent abort; a byte already on the port stays until consumed.
      state_d    = StIdle;
      shift_d    = '0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StHunt;
          shift_d = '0;
        end
        StHunt: begin
          if (bit_rise) begin
            shift_d = shifted;
            if (shifted == SYNC_PATTERN) begin
              state_d       = StPayload;
              frame_start_d = 1'b1;
              bit_cnt_d     = '0;
              byte_cnt_d    = '0;
`ifdef MAN_RX_PARITY_EN
              parity_d      = 1'b0;
`endif
            end
          end
        end
        StPayload: begin
          if (bit_rise) begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef MAN_RX_PARITY_EN
            parity_d  = parity_q ^ bit_sync;
`endif
            if (bit_cnt_q == 3'd7) begin
              if (can_load) begin
                byte_data_d  = shifted;
                byte_valid_d = 1'b1;
                byte_cnt_d   = byte_cnt_q + 4'd1;
                if (byte_cnt_q == LastByte) begin
`ifdef MAN_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d      = StDone;
                  frame_done_d = 1'b1;
`endif
                end
              end else begin
                // Consumer still holds the previous byte: drop the new one.
                state_d     = StHunt;
                shift_d     = '0;
                frame_err_d = 1'b1;
                err_code_d  = ErrOverflow;
              end
            end
          end else if (tmo_hit) begin
            state_d     = StHunt;
            shift_d     = '0;
            frame_err_d = 1'b1;
            err_code_d  = ErrTimeout;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 10'd1;
          end
        end
`ifdef MAN_RX_PARITY_EN
        StParity: begin
          if (bit_rise) begin
            if (parity_q ^ bit_sync) begin
              state_d     = StHunt;
              shift_d     = '0;
              frame_err_d = 1'b1;
              err_code_d  = ErrParity;
            end else begin
              state_d      = StDone;
              frame_done_d = 1'b1;
            end
          end else if (tmo_hit) begin
            state_d     = StHunt;
            shift_d     = '0;
            frame_err_d = 1'b1;
            err_code_d  = ErrTimeout;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 10'd1;
          end
        end
`endif
        StDone: begin
          state_d = StHunt;
          shift_d = '0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      byte_data_q   <= '0;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= ErrNone;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
    end
  end

`ifdef MAN_RX_PARITY_EN
  // Running XOR of the payload bits of the current frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign rx.busy = (state_q == StPayload) || (state_q == StParity);
`else
  assign rx.busy = (state_q == StPayload);
`endif

  assign rx.byte_data   = byte_data_q;
  assign rx.byte_valid  = byte_valid_q;
  assign rx.frame_start = frame_start_q;
  assign rx.frame_done  = frame_done_q;
  assign rx.frame_err   = frame_err_q;
  assign rx.err_code    = err_code_q;

endmodule

// File: doc/manchester_rx_ctrl.md
MANCHESTER_RX_CTRL -- requirements
Module: manchester_rx_ctrl

Interface
REQ-001 SHALL have parameter SYNC_PATTERN, default 8'hD5: frame sync byte, MSB first.
REQ-002 SHALL have parameter PAYLOAD_BYTES, default 4: payload bytes per frame (1..15).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 640: clk cycles without a bit edge before abort (10-bit).
REQ-004 clk  in  1  32 MHz system clock; single clock for all logic.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 enable  in  1  receive enable; low forces IDLE.
REQ-007 bit_clk  in  1  balanced bit clock from decoder; asynchronous to clk.
REQ-008 bit_data  in  1  recovered data from decoder, valid at bit_clk rise.
REQ-009 byte_data  out  8  received payload byte.
REQ-010 byte_valid  out  1  byte_data valid.
REQ-011 byte_ready  in  1  consumer accepts byte.
REQ-012 frame_start  out  1  one-cycle pulse on sync match.
REQ-013 frame_done  out  1  one-cycle pulse on error-free frame completion.
REQ-014 frame_err  out  1  one-cycle pulse on frame abort by error.
REQ-015 err_code  out  2  cause of last error (1 timeout, 2 overflow, 3 parity); held until next error.
REQ-016 busy  out  1  high in PAYLOAD or PARITY.

Function
REQ-017 bit_clk and bit_data SHALL each pass a 2-flop synchronizer; a sampled bit SHALL be taken on the synchronized bit_clk rising edge, 3 clk after the bit_clk rise.
REQ-018 FSM states SHALL be IDLE, HUNT, PAYLOAD, PARITY, DONE; IDLE->HUNT when enable=1.
REQ-019 HUNT: 8-bit shift register SHALL shift left, new bit into LSB; when it equals SYNC_PATTERN the FSM SHALL enter PAYLOAD, pulse frame_start, clear bit and byte counters.
REQ-020 PAYLOAD: every 8th bit SHALL complete a byte, MSB first; byte counter increments; after byte PAYLOAD_BYTES-1 go to PARITY (macro on) or DONE.
REQ-021 Completed byte SHALL load the output register when byte_valid=0 or byte_ready=1 in that cycle; byte_valid=1 the next cycle.
REQ-022 Completed byte with byte_valid=1 and byte_ready=0 SHALL drop the new byte, pulse frame_err, err_code=2, return to HUNT.
REQ-023 byte_data SHALL hold stable while byte_valid=1 and byte_ready=0; byte_valid clears the cycle after byte_ready=1 unless a new byte loads.
REQ-024 Timeout counter SHALL clear on every sampled edge and outside PAYLOAD/PARITY; reaching TIMEOUT_CYC SHALL pulse frame_err, err_code=1, return to HUNT.
REQ-025 Bit edge and timeout in the same cycle: edge SHALL win, no error.
REQ-026 DONE SHALL last one cycle, pulse frame_done, return to HUNT with shift register cleared.
REQ-027 enable=0 SHALL force IDLE next cycle from any state, abort without frame_err; a pending byte_valid SHALL stay until accepted.

Reset
REQ-028 rst=1 SHALL set state IDLE, all counters, shift register, byte_data=0, byte_valid=0, pulses=0, err_code=0, busy=0, synchronizer flops=0.
REQ-029 rst mid-frame SHALL discard the partial frame with no frame_err pulse.

Configuration
REQ-030 MAN_RX_PARITY_EN defined: after the last payload byte, PARITY SHALL take one bit; even parity over all payload bits plus it; mismatch SHALL pulse frame_err, err_code=3, no frame_done.
REQ-031 MAN_RX_PARITY_EN undefined: PARITY state and parity logic SHALL be absent; last byte goes to DONE.

Structure
REQ-032 Package man_rx_pkg SHALL hold the state enum, err_code constants, default SYNC_PATTERN.
REQ-033 Sub-module man_edge_sync SHALL implement the 2-flop synchronizer and rising-edge detect; instantiated for bit_clk, with bit_data sharing its sync stages.

Verification
REQ-034 Send D5 then 11,22,33,44 (parity off), byte_ready=1 -> frame_start, four bytes in order, frame_done once, no frame_err.
REQ-035 Frame of 4 bytes with byte_ready=0 throughout -> byte 11 held, second byte triggers frame_err, err_code=2, state HUNT.
REQ-036 Stop bit_clk after 2 payload bytes -> frame_err exactly TIMEOUT_CYC+1 clk after last edge, err_code=1.
REQ-037 Parity on, payload 01,00,00,00 with parity bit 0 -> frame_err, err_code=3; parity bit 1 -> frame_done.
REQ-038 Pattern D4 then D5 in stream -> single frame_start, at D5 only; enable=0 mid-frame -> IDLE, no frame_err.
REQ-039 rst pulse mid-payload -> all outputs zero next cycle; subsequent D5 frame received correctly.
